// File: rtl/alu_req_unit.sv
// Handshaked 4-bit ALU responder: accepts one request per cycle, computes
// result/carry/zero and returns them in order through a 2-entry FIFO.
module alu_req_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_AND = 3'b010;
    localparam logic [2:0] SEL_OR  = 3'b011;
    localparam logic [2:0] SEL_XOR = 3'b100;
    localparam logic [2:0] SEL_NOT = 3'b101;
    localparam logic [2:0] SEL_SHL = 3'b110;
    localparam logic [2:0] SEL_SHR = 3'b111;

    // Returns {carry, result}; bit WIDTH is the carry-out / borrow / shifted-out bit.
    function automatic logic [WIDTH:0] alu_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       sel
    );
        logic [WIDTH:0] r;
        case (sel)
            SEL_ADD: r = {1'b0, a} + {1'b0, b};
            SEL_SUB: r = {1'b0, a} - {1'b0, b};
            SEL_AND: r = {1'b0, a & b};
            SEL_OR:  r = {1'b0, a | b};
            SEL_XOR: r = {1'b0, a ^ b};
            SEL_NOT: r = {1'b0, ~a};
            SEL_SHL: r = {a, 1'b0};
            SEL_SHR: r = {a[0], 1'b0, a[WIDTH-1:1]};
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] res_mem_r   [2];
    logic             carry_mem_r [2];
    logic             zero_mem_r  [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic [CNT_W-1:0] op_count_r;

    logic [WIDTH:0]   alu_s;
    logic             zero_s;
    logic             push_s;
    logic             pop_s;

    // Combinational ALU on the request fields.
    always_comb begin
        alu_s  = alu_op(in_a, in_b, in_sel);
        zero_s = (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
    end

    // in_ready depends only on registered count and rst, never on out_ready.
    assign in_ready   = (count_r != 2'd2) && !rst;
    assign out_valid  = (count_r != 2'd0) && !rst;
    assign push_s     = in_valid && in_ready;
    assign pop_s      = out_valid && out_ready;

    assign out_result = res_mem_r[rd_ptr_r];
    assign out_carry  = carry_mem_r[rd_ptr_r];
    assign out_zero   = zero_mem_r[rd_ptr_r];
    assign op_count   = op_count_r;

    // FIFO storage, pointers, occupancy and completed-transfer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_mem_r[0]   <= {WIDTH{1'b0}};
            res_mem_r[1]   <= {WIDTH{1'b0}};
            carry_mem_r[0] <= 1'b0;
            carry_mem_r[1] <= 1'b0;
            zero_mem_r[0]  <= 1'b0;
            zero_mem_r[1]  <= 1'b0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            count_r        <= 2'd0;
            op_count_r     <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                res_mem_r[wr_ptr_r]   <= alu_s[WIDTH-1:0];
                carry_mem_r[wr_ptr_r] <= alu_s[WIDTH];
                zero_mem_r[wr_ptr_r]  <= zero_s;
                wr_ptr_r              <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r   <= ~rd_ptr_r;
                op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r   <= rd_ptr_r;
                op_count_r <= op_count_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: doc/alu_req_unit.md
Name: alu_req_unit

Overview:
- Registered, handshaked 4-bit ALU responder; the target end of the A/B/Sel request interface used by the ALU benches.
- Accepts one operation per cycle on a valid/ready request port and computes result, carry and zero.
- Returns results in order through a 2-entry output buffer on a valid/ready response port.
- Sits between a stimulus/sequencer master and a result consumer (checker or display logic).

Parameters:
- WIDTH, 4, operand and result width in bits
- CNT_W, 8, width of the completed-operation counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at a clk edge
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sel  input  3  operation select
- out_valid  output  1  response valid (buffer non-empty)
- out_ready  input  1  consumer takes the response when out_valid && out_ready
- out_result  output  WIDTH  head-entry result
- out_carry  output  1  head-entry carry/borrow
- out_zero  output  1  head entry: 1 when result == 0
- op_count  output  CNT_W  count of completed response transfers

Behaviour:
- Reset is synchronous. While rst is high at a clk edge:
  - buffer cleared: count=0, read and write pointers 0, both entries 0
  - out_valid=0, out_result=0, out_carry=0, out_zero=0, op_count=0
  - in_ready is forced 0 while rst is asserted and goes to 1 on the first cycle after reset
- Opcode map, in_sel to result and carry (carry is the WIDTH+1-bit arithmetic bit):
  - 000 ADD: A+B; carry = carry-out
  - 001 SUB: A-B mod 2^WIDTH; carry = borrow (1 iff A<B)
  - 010 AND: carry=0
  - 011 OR: carry=0
  - 100 XOR: carry=0
  - 101 NOT A: carry=0
  - 110 SHL A by 1: carry = A[WIDTH-1], LSB filled with 0
  - 111 SHR A by 1 (logical): carry = A[0], MSB filled with 0
- Zero flag: zero = (result == 0), computed on the truncated result.
- Computation is combinational on the request fields; result, carry and zero are written into the buffer at the accepting edge.
- Latency: a request accepted at edge N makes its response visible at the head (out_valid=1) after edge N when the buffer was empty. Throughput is 1 op/cycle while out_ready=1.
- Buffer: 2-entry FIFO with registered count 0..2.
  - in_ready = (count != 2) && !rst; no combinational path from out_ready to in_ready.
  - Push only: count+1. Pop only: count-1. Push and pop in the same cycle: count unchanged, head advances, new entry written at the tail.
  - Full (count=2): in_ready=0; a pop that cycle gives count=1 and in_ready=1 in the next cycle.
  - Empty: out_valid=0; out_result, out_carry and out_zero show the stale head entry and must not be used.
  - Order is strictly FIFO. A response that is held (out_valid=1, out_ready=0) keeps all out_* stable.
- op_count increments on each out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: buffered results are discarded and not delivered, and op_count returns to 0.

Test Plan:
- All opcodes, out_ready=1, in_a=1010, in_b=1111, in_sel stepped 000..111 on consecutive cycles. Responses in order, each 1 cycle after acceptance:
  - 000: 1001, carry 1
  - 001: 1011, carry 1
  - 010: 1010, carry 0
  - 011: 1111, carry 0
  - 100: 0101, carry 0
  - 101: 0101, carry 0
  - 110: 0100, carry 1
  - 111: 0101, carry 0
  - op_count reaches 8
- Zero flag: in_a=0101, in_b=1010, sel=010 -> out_result=0000, out_zero=1, out_carry=0. Then in_a=0000, in_b=0000, sel=000 -> zero=1, carry=0.
- Backpressure: out_ready=0, three back-to-back requests (ADD, SUB, AND on 1010/1111).
  - First two accepted; in_ready=0 from the cycle after the second acceptance; third request held on the bus.
  - Raise out_ready: ADD pops first, then the third is accepted in the cycle after the pop.
  - Outputs delivered in order ADD, SUB, AND.
- Simultaneous push/pop at count=1: count stays 1, in_ready stays 1, and ordering is preserved across 4 ops.
- Reset mid-stream: with 2 entries buffered, assert rst for 1 cycle.
  - out_valid=0 and in_ready=0 during rst; op_count=0 afterwards.
  - No stale results are delivered; the next request after reset returns correctly.
- Counter wrap: complete 256 transfers -> op_count returns to 0 on the 256th.
